mmio_regfile_gen: RTL and testbench

- Parametrised MMIO register file for the AFU: decodes host MMIO reads and writes to a configurable bank of read-only status registers and read/write control registers.
- Adds features over the fixed-map block:
  - 32-bit half-register writes with merge.
  - Per-register pulse/hold mode.
  - Sticky parity errors with explicit clear.
  - Fixed-latency pipelined acknowledge that accepts back-to-back requests.
- Sits between the PSL MMIO interface and the compute-unit control/status logic; configuration-space (AFU descriptor) accesses are outside this block.

---
 rtl/mmio_regfile_gen.sv | 186 ++++++++++++++++++
 tb/tb_mmio_regfile_gen.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_regfile_gen.sv
// MMIO register file: RO status and RW control registers behind a fixed 3-stage pipeline.
// IBM bit numbering on the bus: mmio_addr[0] here is the half-select bit, wdata[31:0] is wdata[32:63].
module mmio_regfile_gen #(
    parameter int unsigned           NUM_RO         = 16,
    parameter int unsigned           NUM_RW         = 4,
    parameter int unsigned           ADDR_WIDTH     = 24,
    parameter logic [ADDR_WIDTH-1:0] RO_BASE        = 24'h00_0000,
    parameter logic [ADDR_WIDTH-1:0] RW_BASE        = 24'h00_0100,
    parameter logic [31:0]           PULSE_MASK     = 32'h0,
    parameter logic [63:0]           UNMAPPED_RDATA = 64'h0
) (
    input  logic                    clock,
    input  logic                    rstn,
    input  logic                    mmio_valid,
    input  logic                    mmio_read,
    input  logic                    mmio_dw,
    input  logic [ADDR_WIDTH-1:0]   mmio_addr,
    input  logic                    mmio_addr_par,
    input  logic [63:0]             mmio_wdata,
    input  logic                    mmio_wdata_par,
    output logic                    mmio_ack,
    output logic [63:0]             mmio_rdata,
    output logic                    mmio_rdata_par,
    input  logic [NUM_RO*64-1:0]    ro_data,
    output logic [NUM_RW*64-1:0]    rw_data,
    output logic [NUM_RW-1:0]       rw_wr_strobe,
    input  logic                    err_clear,
    output logic [1:0]              mmio_errors
);

    localparam int unsigned IW = ADDR_WIDTH - 1;

    // Stage 1: captured request
    logic                  s1_valid, s1_read, s1_dw, s1_addr_par, s1_wdata_par;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [63:0]           s1_wdata;

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            s1_valid     <= 1'b0;
            s1_read      <= 1'b0;
            s1_dw        <= 1'b0;
            s1_addr      <= '0;
            s1_addr_par  <= 1'b0;
            s1_wdata     <= '0;
            s1_wdata_par <= 1'b0;
        end else begin
            s1_valid <= mmio_valid;
            if (mmio_valid) begin
                s1_read      <= mmio_read;
                s1_dw        <= mmio_dw;
                s1_addr      <= mmio_addr;
                s1_addr_par  <= mmio_addr_par;
                s1_wdata     <= mmio_wdata;
                s1_wdata_par <= mmio_wdata_par;
            end
        end
    end

    // Decode and parity check; ro_data is sampled here, in the cycle after the request
    logic [IW-1:0]     ro_idx, rw_idx;
    logic              ro_hit, addr_ok, data_ok;
    logic [63:0]       ro_word;
    logic [NUM_RW-1:0] rw_sel;

    assign ro_idx  = s1_addr[ADDR_WIDTH-1:1] - RO_BASE[ADDR_WIDTH-1:1];
    assign rw_idx  = s1_addr[ADDR_WIDTH-1:1] - RW_BASE[ADDR_WIDTH-1:1];
    assign ro_hit  = (ro_idx < IW'(NUM_RO));
    assign addr_ok = ^{s1_addr, s1_addr_par};
    assign data_ok = ^{s1_wdata, s1_wdata_par};

    always_comb begin
        ro_word = '0;
        for (int i = 0; i < NUM_RO; i++) begin
            if (ro_idx == IW'(i)) ro_word = ro_data[i*64 +: 64];
        end
        rw_sel = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            rw_sel[i] = (rw_idx == IW'(i));
        end
    end

    // Stage 2: decoded request
    logic              s2_valid, s2_read, s2_dw, s2_half, s2_addr_ok, s2_data_ok, s2_ro_hit;
    logic [NUM_RW-1:0] s2_rw_sel;
    logic [63:0]       s2_ro_word, s2_wdata;

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            s2_valid   <= 1'b0;
            s2_read    <= 1'b0;
            s2_dw      <= 1'b0;
            s2_half    <= 1'b0;
            s2_addr_ok <= 1'b0;
            s2_data_ok <= 1'b0;
            s2_ro_hit  <= 1'b0;
            s2_rw_sel  <= '0;
            s2_ro_word <= '0;
            s2_wdata   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_read    <= s1_read;
                s2_dw      <= s1_dw;
                s2_half    <= s1_addr[0];
                s2_addr_ok <= addr_ok;
                s2_data_ok <= data_ok;
                s2_ro_hit  <= ro_hit;
                s2_rw_sel  <= rw_sel;
                s2_ro_word <= ro_word;
                s2_wdata   <= s1_wdata;
            end
        end
    end

    // Stage 3: apply write / select read data, issue ack
    logic [63:0]       rw_q [NUM_RW];
    logic [63:0]       rw_d [NUM_RW];
    logic [NUM_RW-1:0] strobe_q, strobe_d;
    logic              ack_q;
    logic [63:0]       rdata_q, rdata_d, rd_word;
    logic [31:0]       half_word;
    logic [1:0]        errors_q, errors_d, err_set;
    logic              wr_ok, hit;

    always_comb begin
        rw_d     = rw_q;
        strobe_d = '0;
        rd_word  = '0;
        rdata_d  = '0;
        // Pulse registers only hold a written value for the cycle of the write
        for (int i = 0; i < NUM_RW; i++) begin
            if (PULSE_MASK[i]) rw_d[i] = '0;
            if (s2_rw_sel[i]) rd_word = rw_q[i];
        end
        if (s2_ro_hit) rd_word = s2_ro_word;
        hit       = s2_ro_hit | (|s2_rw_sel);
        half_word = s2_half ? rd_word[31:0] : rd_word[63:32];
        if (s2_valid && s2_read) begin
            if (!s2_addr_ok || !hit) rdata_d = UNMAPPED_RDATA;
            else if (s2_dw)          rdata_d = rd_word;
            else                     rdata_d = {half_word, half_word};
        end
        wr_ok = s2_valid & ~s2_read & s2_addr_ok & s2_data_ok;
        for (int i = 0; i < NUM_RW; i++) begin
            if (wr_ok && s2_rw_sel[i]) begin
                if (s2_dw)        rw_d[i] = s2_wdata;
                else if (s2_half) rw_d[i] = {rw_q[i][63:32], s2_wdata[31:0]};
                else              rw_d[i] = {s2_wdata[31:0], rw_q[i][31:0]};
                strobe_d[i] = 1'b1;
            end
        end
        err_set[1] = s2_valid & ~s2_addr_ok;
        err_set[0] = s2_valid & ~s2_read & ~s2_data_ok;
        // A new error in the clearing cycle wins
        errors_d   = (errors_q & ~{2{err_clear}}) | err_set;
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            strobe_q <= '0;
            errors_q <= '0;
            for (int i = 0; i < NUM_RW; i++) rw_q[i] <= '0;
        end else begin
            ack_q    <= s2_valid;
            rdata_q  <= rdata_d;
            strobe_q <= strobe_d;
            errors_q <= errors_d;
            rw_q     <= rw_d;
        end
    end

    always_comb begin
        rw_data = '0;
        for (int i = 0; i < NUM_RW; i++) rw_data[i*64 +: 64] = rw_q[i];
    end

    assign mmio_ack       = ack_q;
    assign mmio_rdata     = rdata_q;
    assign mmio_rdata_par = ~^rdata_q;
    assign rw_wr_strobe   = strobe_q;
    assign mmio_errors    = errors_q;

endmodule

// File: tb/tb_mmio_regfile_gen.sv
// Bench for mmio_regfile_gen: directed vector table, parity/reset sequences, random vs model.
module tb_mmio_regfile_gen;

    localparam int          NRO   = 16;
    localparam int          NRW   = 4;
    localparam int          ROB   = 'h000;
    localparam int          RWB   = 'h100;
    localparam logic [31:0] PMASK = 32'h1;
    localparam logic [63:0] UNM   = 64'hBAD0_BAD0_0BAD_0BAD;

    logic           clock = 1'b0;
    logic           rstn;
    logic           mmio_valid, mmio_read, mmio_dw, mmio_addr_par, mmio_wdata_par;
    logic [23:0]    mmio_addr;
    logic [63:0]    mmio_wdata;
    logic           mmio_ack, mmio_rdata_par, err_clear;
    logic [63:0]    mmio_rdata;
    logic [NRO*64-1:0] ro_data;
    logic [NRW*64-1:0] rw_data;
    logic [NRW-1:0] rw_wr_strobe;
    logic [1:0]     mmio_errors;

    mmio_regfile_gen #(
        .NUM_RO(NRO), .NUM_RW(NRW), .ADDR_WIDTH(24), .RO_BASE(24'h00_0000),
        .RW_BASE(24'h00_0100), .PULSE_MASK(PMASK), .UNMAPPED_RDATA(UNM)
    ) dut (
        .clock(clock), .rstn(rstn), .mmio_valid(mmio_valid), .mmio_read(mmio_read),
        .mmio_dw(mmio_dw), .mmio_addr(mmio_addr), .mmio_addr_par(mmio_addr_par),
        .mmio_wdata(mmio_wdata), .mmio_wdata_par(mmio_wdata_par), .mmio_ack(mmio_ack),
        .mmio_rdata(mmio_rdata), .mmio_rdata_par(mmio_rdata_par), .ro_data(ro_data),
        .rw_data(rw_data), .rw_wr_strobe(rw_wr_strobe), .err_clear(err_clear),
        .mmio_errors(mmio_errors)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic        v, rd, dw;
        logic [23:0] addr;
        logic [63:0] wdata;
        logic        bad_ap, bad_dp, chk;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        int           due;
        logic         chk_rd;
        logic [63:0]  rdata;
        logic [255:0] rw;
        logic [3:0]   stb;
        logic [1:0]   err;
    } exp_t;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    vec_t tbl[$];

    // Reference state: register contents, last accepted write cycle, sticky errors
    logic [63:0] ro_vals [NRO];
    logic [63:0] rw_m [NRW];
    int          wr_cyc [NRW];
    logic [1:0]  err_m;
    logic [31:0] pmask_v;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic rd, input logic dw,
                                input logic [23:0] addr, input logic [63:0] wdata,
                                input logic bap, input logic bdp,
                                input logic chk, input logic [63:0] exp);
        vec_t r;
        r.v = v; r.rd = rd; r.dw = dw; r.addr = addr; r.wdata = wdata;
        r.bad_ap = bap; r.bad_dp = bdp; r.chk = chk; r.exp = exp;
        return r;
    endfunction

    function automatic vec_t idle();
        return mk(0, 0, 0, 24'h0, 64'h0, 0, 0, 0, 64'h0);
    endfunction

    // Value a request issued in cycle c observes; a pulse register only shows a write from c-1
    function automatic logic [63:0] visible(input int i, input int c);
        if (pmask_v[i]) return (wr_cyc[i] == c - 1) ? rw_m[i] : 64'h0;
        return rw_m[i];
    endfunction

    function automatic logic [255:0] snapshot(input int c);
        logic [255:0] s;
        for (int i = 0; i < NRW; i++) begin
            if (pmask_v[i]) s[i*64 +: 64] = (wr_cyc[i] == c) ? rw_m[i] : 64'h0;
            else            s[i*64 +: 64] = rw_m[i];
        end
        return s;
    endfunction

    function automatic exp_t model(input vec_t r, input int c);
        exp_t e;
        int a = int'(r.addr);
        logic [63:0] cur, nv;
        int ri = (a - RWB) / 2;
        logic in_ro = (a >= ROB) && (a < ROB + 2 * NRO);
        logic in_rw = (a >= RWB) && (a < RWB + 2 * NRW);
        e.due = c + 3; e.chk_rd = r.rd; e.rdata = UNM; e.stb = '0;
        if (r.bad_ap) err_m[1] = 1'b1;
        if (!r.rd && r.bad_dp) err_m[0] = 1'b1;
        if (r.rd) begin
            if (!r.bad_ap && (in_ro || in_rw)) begin
                cur = in_ro ? ro_vals[(a - ROB) / 2] : visible(ri, c);
                if (r.dw)         e.rdata = cur;
                else if (a % 2)   e.rdata = {cur[31:0], cur[31:0]};
                else              e.rdata = {cur[63:32], cur[63:32]};
            end
        end else if (!r.bad_ap && !r.bad_dp && in_rw) begin
            cur = visible(ri, c);
            if (r.dw)       nv = r.wdata;
            else if (a % 2) nv = {cur[63:32], r.wdata[31:0]};
            else            nv = {r.wdata[31:0], cur[31:0]};
            rw_m[ri] = nv;
            wr_cyc[ri] = c;
            e.stb[ri] = 1'b1;
        end
        e.rw  = snapshot(c);
        e.err = err_m;
        if (r.chk) begin
            e.chk_rd = 1'b1;
            e.rdata = r.exp;
        end
        return e;
    endfunction

    task automatic monitor();
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("ack", mmio_ack, 1'b1);
            if (e.chk_rd) check("rdata", mmio_rdata, e.rdata);
            check("rw_data", rw_data, e.rw);
            check("rw_wr_strobe", rw_wr_strobe, e.stb);
            check("mmio_errors", mmio_errors, e.err);
        end else begin
            check("no_ack", mmio_ack, 1'b0);
        end
        check("rdata_par", mmio_rdata_par, ~^mmio_rdata);
    endtask

    task automatic tick(input vec_t r, input logic clr);
        @(posedge clock);
        #1;
        mmio_valid     = r.v;
        mmio_read      = r.rd;
        mmio_dw        = r.dw;
        mmio_addr      = r.addr;
        mmio_addr_par  = (~^r.addr) ^ r.bad_ap;
        mmio_wdata     = r.wdata;
        mmio_wdata_par = (~^r.wdata) ^ r.bad_dp;
        err_clear      = clr;
        if (r.v) exp_q.push_back(model(r, cyc));
        @(negedge clock);
        monitor();
    endtask

    task automatic model_reset();
        for (int i = 0; i < NRW; i++) begin
            rw_m[i] = '0;
            wr_cyc[i] = -100;
        end
        err_m = '0;
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, mmio_ack, 1'b0);
        check({tag, "_rdata"}, mmio_rdata, 64'h0);
        check({tag, "_rdata_par"}, mmio_rdata_par, 1'b1);
        check({tag, "_rw_data"}, rw_data, 256'h0);
        check({tag, "_strobe"}, rw_wr_strobe, 4'h0);
        check({tag, "_errors"}, mmio_errors, 2'b00);
    endtask

    initial begin
        vec_t r;
        pmask_v = PMASK;
        rstn = 1'b0;
        mmio_valid = 0; mmio_read = 0; mmio_dw = 0; mmio_addr = '0; mmio_addr_par = 1;
        mmio_wdata = '0; mmio_wdata_par = 1; err_clear = 0;
        for (int i = 0; i < NRO; i++)
            ro_vals[i] = 64'h5A5A_0000_0F0F_0000 | (64'(i) << 40) | (64'(i) << 8);
        ro_vals[3] = 64'h0000_0000_0000_0ABC;
        for (int i = 0; i < NRO; i++) ro_data[i*64 +: 64] = ro_vals[i];
        model_reset();

        repeat (2) @(negedge clock);
        check_reset_outputs("reset");
        rstn = 1'b1;

        // Directed vectors, applied back to back
        tbl.push_back(mk(1, 0, 1, 24'h102, 64'hDEAD_BEEF_0123_4567, 0, 0, 0, 64'h0));
        tbl.push_back(mk(1, 1, 1, 24'h102, 64'h0, 0, 0, 1, 64'hDEAD_BEEF_0123_4567));
        tbl.push_back(mk(0, 0, 0, 24'h0, 64'h0, 0, 0, 0, 64'h0));
        tbl.push_back(mk(1, 0, 1, 24'h104, 64'h1111_1111_2222_2222, 0, 0, 0, 64'h0));
        tbl.push_back(mk(1, 0, 0, 24'h105, 64'h0000_0000_AAAA_AAAA, 0, 0, 0, 64'h0));
        tbl.push_back(mk(1, 1, 1, 24'h104, 64'h0, 0, 0, 1, 64'h1111_1111_AAAA_AAAA));
        tbl.push_back(mk(1, 1, 0, 24'h104, 64'h0, 0, 0, 1, 64'h1111_1111_1111_1111));
        tbl.push_back(mk(1, 1, 0, 24'h105, 64'h0, 0, 0, 1, 64'hAAAA_AAAA_AAAA_AAAA));
        tbl.push_back(mk(1, 0, 0, 24'h104, 64'hFFFF_FFFF_3333_3333, 0, 0, 0, 64'h0));
        tbl.push_back(mk(1, 1, 1, 24'h104, 64'h0, 0, 0, 1, 64'h3333_3333_AAAA_AAAA));
        tbl.push_back(mk(1, 1, 1, 24'h006, 64'h0, 0, 0, 1, 64'h0000_0000_0000_0ABC));
        tbl.push_back(mk(1, 1, 0, 24'h007, 64'h0, 0, 0, 1, 64'h0000_0ABC_0000_0ABC));
        tbl.push_back(mk(1, 1, 1, 24'h020, 64'h0, 0, 0, 1, UNM));
        tbl.push_back(mk(1, 0, 1, 24'h000, 64'h1234_5678_9ABC_DEF0, 0, 0, 0, 64'h0));
        tbl.push_back(mk(1, 1, 1, 24'h000, 64'h0, 0, 0, 1, 64'h5A5A_0000_0F0F_0000));
        tbl.push_back(mk(1, 1, 1, 24'h108, 64'h0, 0, 0, 1, UNM));
        tbl.push_back(mk(1, 1, 1, 24'h0FE, 64'h0, 0, 0, 1, UNM));
        tbl.push_back(mk(1, 0, 1, 24'h100, 64'h5, 0, 0, 0, 64'h0));
        tbl.push_back(mk(1, 1, 1, 24'h100, 64'h0, 0, 0, 1, 64'h5));
        tbl.push_back(mk(1, 1, 1, 24'h100, 64'h0, 0, 0, 1, 64'h0));
        tbl.push_back(mk(1, 0, 1, 24'h100, 64'h5, 0, 0, 0, 64'h0));
        tbl.push_back(mk(1, 0, 0, 24'h100, 64'h0000_0000_0000_0007, 0, 0, 0, 64'h0));
        tbl.push_back(mk(1, 1, 1, 24'h100, 64'h0, 0, 0, 1, 64'h0000_0007_0000_0005));
        tbl.push_back(mk(1, 1, 1, 24'h100, 64'h0, 0, 0, 1, 64'h0));
        foreach (tbl[i]) tick(tbl[i], 1'b0);
        repeat (4) tick(idle(), 1'b0);

        // Bad write-data parity: dropped, sticky error held
        tick(mk(1, 0, 1, 24'h102, 64'h0000_0000_0000_1234, 0, 1, 0, 64'h0), 1'b0);
        repeat (5) tick(idle(), 1'b0);
        check("err_hold", mmio_errors, 2'b01);
        check("rw1_kept", rw_data[127:64], 64'hDEAD_BEEF_0123_4567);
        tick(mk(1, 1, 1, 24'h102, 64'h0, 1, 0, 1, UNM), 1'b0);
        repeat (4) tick(idle(), 1'b0);
        check("err_both", mmio_errors, 2'b11);
        tick(idle(), 1'b1);
        tick(idle(), 1'b0);
        check("err_cleared", mmio_errors, 2'b00);
        err_m = '0;

        // Clear in the same cycle a new error lands: the error stays
        tick(mk(1, 0, 1, 24'h102, 64'h0000_0000_0000_4321, 0, 1, 0, 64'h0), 1'b0);
        tick(idle(), 1'b0);
        tick(idle(), 1'b1);
        tick(idle(), 1'b0);
        tick(idle(), 1'b0);
        check("err_new_wins", mmio_errors, 2'b01);
        tick(idle(), 1'b1);
        tick(idle(), 1'b0);
        check("err_cleared2", mmio_errors, 2'b00);
        err_m = '0;

        // Random traffic against the model
        for (int n = 0; n < 500; n++) begin
            r = idle();
            r.v = ($urandom_range(3) != 0);
            r.rd = 1'($urandom_range(1));
            r.dw = 1'($urandom_range(1));
            r.wdata = {$urandom, $urandom};
            r.bad_ap = ($urandom_range(15) == 0);
            r.bad_dp = ($urandom_range(15) == 0);
            case ($urandom_range(4))
                0:       r.addr = 24'(ROB + $urandom_range(2 * NRO - 1));
                1, 2:    r.addr = 24'(RWB + $urandom_range(2 * NRW - 1));
                3: begin
                    case ($urandom_range(3))
                        0:       r.addr = 24'(ROB + 2 * NRO + $urandom_range(1));
                        1:       r.addr = 24'(RWB - 2 + $urandom_range(1));
                        default: r.addr = 24'(RWB + 2 * NRW + $urandom_range(1));
                    endcase
                end
                default: r.addr = 24'($urandom);
            endcase
            tick(r, 1'b0);
        end
        repeat (4) tick(idle(), 1'b0);

        // Reset with three requests in flight
        tick(mk(1, 0, 1, 24'h106, 64'h0000_0000_0000_0077, 0, 0, 0, 64'h0), 1'b0);
        tick(mk(1, 1, 1, 24'h102, 64'h0, 0, 0, 0, 64'h0), 1'b0);
        tick(mk(1, 0, 1, 24'h104, 64'h0000_0000_0000_0099, 0, 0, 0, 64'h0), 1'b0);
        rstn = 1'b0;
        mmio_valid = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        repeat (2) begin
            @(negedge clock);
            check("reset_hold_ack", mmio_ack, 1'b0);
        end
        rstn = 1'b1;
        repeat (4) tick(idle(), 1'b0);
        tick(mk(1, 0, 1, 24'h106, 64'hCAFE_F00D_0000_0001, 0, 0, 0, 64'h0), 1'b0);
        tick(mk(1, 1, 1, 24'h106, 64'h0, 0, 0, 1, 64'hCAFE_F00D_0000_0001), 1'b0);
        repeat (4) tick(idle(), 1'b0);
        check("drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
